pipe_reg_sync: RTL
==================

PIPE_REG_SYNC -- requirements
Module: pipe_reg_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of register stages (legal range 1..16).
REQ-003 The block SHALL have parameter RST_VAL, default 0, WIDTH-bit value loaded into every stage data register on reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous pipeline clear, active high.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream data valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: upstream data.
REQ-010 The block SHALL have port out_valid, output, 1 bit: valid bit of stage DEPTH-1.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: data register of stage DEPTH-1.

Function
REQ-013 The block SHALL implement DEPTH stages, each holding a WIDTH-bit data register and a valid bit v[i]; stage 0 is the input end and stage DEPTH-1 drives out_valid/out_data directly.
REQ-014 The block SHALL complete a transfer on any edge where valid and ready are both high, on either port.
REQ-015 Stage DEPTH-1 SHALL be able to take new data when v[DEPTH-1]=0 or out_ready=1; stage i<DEPTH-1 SHALL be able to take new data when v[i]=0 or stage i+1 can take new data (bubbles collapse).
REQ-016 in_ready SHALL equal "stage 0 can take new data" AND NOT flush; it SHALL be a combinational function of out_ready and register state only, and SHALL NOT depend on in_valid.
REQ-017 A stage that can take new data SHALL load data and valid from its predecessor (stage 0 loads from in_data and in_valid AND in_ready); a stage that cannot SHALL hold its data and valid unchanged.
REQ-018 A stage whose valid bit loads 0 SHALL still load its predecessor's data; data in invalid stages is don't-care but SHALL be deterministic.
REQ-019 With out_ready held high, a word accepted at edge N SHALL appear with out_valid=1 after edge N+DEPTH-1 (latency DEPTH-1 cycles from acceptance; for DEPTH=1 it appears in the cycle after acceptance) and throughput SHALL be one word per cycle.
REQ-020 When all stages are valid and out_ready=0, in_ready SHALL be 0 and every stage SHALL hold.
REQ-021 Words SHALL leave in acceptance order with no loss or duplication.
REQ-022 When flush=1 at an edge, all v[i] SHALL clear to 0, data registers SHALL hold, and no input SHALL be accepted; an output transfer in the same cycle (out_valid=1 and out_ready=1) SHALL still count as delivered.

Reset
REQ-023 When rst=1 at a rising clk edge, every v[i] SHALL clear to 0 and every data register SHALL load RST_VAL, giving out_valid=0 and out_data=RST_VAL after that edge.
REQ-024 rst SHALL take priority over flush and over any transfer in the same cycle; in-flight words SHALL be discarded on reset mid-stream.
REQ-025 While rst=1, in_ready SHALL be 0.

Configuration
REQ-026 When macro PIPE_REG_SYNC_OCCUPANCY_EN is defined, the block SHALL add output port occupancy, width clog2(DEPTH+1), equal to the number of set v[i] bits, combinational from registers, 0 after reset or flush.
REQ-027 When PIPE_REG_SYNC_OCCUPANCY_EN is not defined, port occupancy and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Reset: with WIDTH=8, DEPTH=4, RST_VAL=8'hA5, rst high 2 cycles -> out_valid=0, out_data=8'hA5, in_ready=0 during reset and 1 after release.
REQ-029 Streaming: out_ready=1, send 8'h01..8'h08 on consecutive cycles -> 8'h01 out_valid after edge 3 past acceptance, then one word per cycle in order, no gaps.
REQ-030 Backpressure: out_ready=0, offer 6 words -> exactly 4 accepted, in_ready=0 afterwards; raise out_ready -> 4 words out in order, in_ready high the same cycle out_ready rises.
REQ-031 Bubble collapse: single word 8'h3C, out_ready=0 -> word reaches stage 3 and holds; next 3 words accepted back-to-back without stall.
REQ-032 Flush: 3 words in flight, flush pulse with in_valid=1 -> in_ready=0 that cycle, out_valid=0 after the edge, flushed words never appear, occupancy=0 if enabled.
REQ-033 Reset mid-stream with flush also high -> state equals post-reset values of REQ-028; with macro defined, occupancy tracks 0..4 correctly through REQ-030.

Source files
------------

// File: rtl/pipe_reg_sync.sv
// rtl/pipe_reg_sync.sv - DEPTH-stage valid/ready register pipeline with collapsing bubbles.
// Optional occupancy output under macro PIPE_REG_SYNC_OCCUPANCY_EN.
module pipe_reg_sync #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_SYNC_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] can_take;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic             take;

  // A stage can load if any stage at or downstream of it is empty, or the output drains.
  always_comb begin
    take     = out_ready;
    can_take = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      take        = take | ~v_q[i];
      can_take[i] = take;
    end
  end

  assign in_ready  = can_take[0] & ~flush & ~rst;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (can_take[0]) begin
        data_d[0] = in_data;
        v_d[0]    = in_valid & in_ready;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (can_take[i]) begin
          data_d[i] = data_q[i-1];
          v_d[i]    = v_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= RST_VAL;
      end
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

`ifdef PIPE_REG_SYNC_OCCUPANCY_EN
  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occupancy = occupancy + OCC_W'(v_q[i]);
    end
  end
`endif

endmodule
